// File: rtl/alu_exec_unit.sv
// LEGv8 execute-stage ALU: single-cycle AND/ORR/ADD/SUB/EOR/LSL/LSR/PASS_B plus an
// iterative shift-add MUL, with a valid/ready handshake on both request and result.
module alu_exec_unit #(
    parameter int DATA_W = 64,
    parameter int SH_W   = $clog2(DATA_W)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        alu_op_class,
    input  logic [10:0]       opcode,
    input  logic [DATA_W-1:0] operand_a,
    input  logic [DATA_W-1:0] operand_b,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] result,
    output logic              flag_n,
    output logic              flag_z,
    output logic              flag_c,
    output logic              flag_v,
    output logic [3:0]        alu_code,
    output logic              illegal
);

    // Handshake: a request transfers on an edge where in_valid && in_ready and flush
    // is low; a result transfers on an edge where out_valid && out_ready.
    localparam logic [3:0] C_AND = 4'd0, C_ORR = 4'd1, C_ADD = 4'd2, C_EOR = 4'd3;
    localparam logic [3:0] C_LSL = 4'd4, C_LSR = 4'd5, C_SUB = 4'd6, C_PASS = 4'd7;
    localparam logic [3:0] C_MUL = 4'd8, C_ILL = 4'd15;

    typedef enum logic {ST_IDLE, ST_MUL} state_t;

    state_t            state_q, state_d;
    logic [SH_W-1:0]   cnt_q, cnt_d;
    logic [DATA_W-1:0] mca_q, mca_d;
    logic [DATA_W-1:0] mpb_q, mpb_d;
    logic [DATA_W-1:0] acc_q, acc_d;
    logic              out_valid_q, out_valid_d;
    logic [DATA_W-1:0] result_q, result_d;
    logic              n_q, n_d, z_q, z_d, c_q, c_d, v_q, v_d;
    logic [3:0]        code_q, code_d;
    logic              illegal_q, illegal_d;

    logic [3:0]        dec_code;
    logic              dec_illegal;
    logic [DATA_W:0]   add_full, sub_full;
    logic [DATA_W-1:0] op_res, mul_step, mul_sum;
    logic              op_c, op_v, accept;

    always_comb begin
        dec_code    = C_ILL;
        dec_illegal = 1'b0;
        case ({alu_op_class, opcode})
            {2'b00, 11'b00000000000},
            {2'b00, 11'b11111000010},
            {2'b00, 11'b11111000000}: dec_code = C_ADD;
            {2'b01, 11'b00000000000},
            {2'b01, 11'b10110100000}: dec_code = C_PASS;
            {2'b10, 11'b10001010000}: dec_code = C_AND;
            {2'b10, 11'b10101010000}: dec_code = C_ORR;
            {2'b10, 11'b10001011000}: dec_code = C_ADD;
            {2'b10, 11'b11001011000}: dec_code = C_SUB;
            {2'b10, 11'b11001010000}: dec_code = C_EOR;
            {2'b10, 11'b11010011011}: dec_code = C_LSL;
            {2'b10, 11'b11010011010}: dec_code = C_LSR;
            {2'b10, 11'b10011011000}: dec_code = C_MUL;
            default:                  dec_illegal = 1'b1;
        endcase
    end

    assign add_full = {1'b0, operand_a} + {1'b0, operand_b};
    assign sub_full = {1'b0, operand_a} + {1'b0, ~operand_b} + (DATA_W+1)'(1);

    always_comb begin
        op_res = '0;
        op_c   = 1'b0;
        op_v   = 1'b0;
        case (dec_code)
            C_AND:  op_res = operand_a & operand_b;
            C_ORR:  op_res = operand_a | operand_b;
            C_EOR:  op_res = operand_a ^ operand_b;
            C_LSL:  op_res = operand_a << operand_b[SH_W-1:0];
            C_LSR:  op_res = operand_a >> operand_b[SH_W-1:0];
            C_PASS: op_res = operand_b;
            C_ADD: begin
                op_res = add_full[DATA_W-1:0];
                op_c   = add_full[DATA_W];
                op_v   = (operand_a[DATA_W-1] == operand_b[DATA_W-1]) &&
                         (add_full[DATA_W-1] != operand_a[DATA_W-1]);
            end
            C_SUB: begin
                op_res = sub_full[DATA_W-1:0];
                op_c   = sub_full[DATA_W];
                op_v   = (operand_a[DATA_W-1] != operand_b[DATA_W-1]) &&
                         (sub_full[DATA_W-1] != operand_a[DATA_W-1]);
            end
            default: op_res = '0;
        endcase
    end

    // One partial product per MUL cycle, selected by multiplier bit cnt_q.
    assign mul_step = mpb_q[cnt_q] ? (mca_q << cnt_q) : '0;
    assign mul_sum  = acc_q + mul_step;

    assign in_ready = (state_q == ST_IDLE) && (!out_valid_q || out_ready) && !reset;
    assign accept   = in_valid && in_ready && !flush;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        mca_d       = mca_q;
        mpb_d       = mpb_q;
        acc_d       = acc_q;
        out_valid_d = out_valid_q && !out_ready;
        result_d    = result_q;
        n_d         = n_q;
        z_d         = z_q;
        c_d         = c_q;
        v_d         = v_q;
        code_d      = code_q;
        illegal_d   = illegal_q;
        if (flush) begin
            out_valid_d = 1'b0;
            state_d     = ST_IDLE;
            cnt_d       = '0;
        end else if (state_q == ST_MUL) begin
            acc_d = mul_sum;
            cnt_d = cnt_q + SH_W'(1);
            if (cnt_q == SH_W'(DATA_W - 1)) begin
                state_d     = ST_IDLE;
                cnt_d       = '0;
                out_valid_d = 1'b1;
                result_d    = mul_sum;
                n_d         = mul_sum[DATA_W-1];
                z_d         = (mul_sum == '0);
                c_d         = 1'b0;
                v_d         = 1'b0;
                code_d      = C_MUL;
                illegal_d   = 1'b0;
            end
        end else if (accept) begin
            if (dec_code == C_MUL) begin
                state_d = ST_MUL;
                cnt_d   = '0;
                acc_d   = '0;
                mca_d   = operand_a;
                mpb_d   = operand_b;
            end else begin
                out_valid_d = 1'b1;
                result_d    = op_res;
                n_d         = op_res[DATA_W-1];
                z_d         = (op_res == '0) && !dec_illegal;
                c_d         = op_c;
                v_d         = op_v;
                code_d      = dec_code;
                illegal_d   = dec_illegal;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            mca_q       <= '0;
            mpb_q       <= '0;
            acc_q       <= '0;
            out_valid_q <= 1'b0;
            result_q    <= '0;
            n_q         <= 1'b0;
            z_q         <= 1'b0;
            c_q         <= 1'b0;
            v_q         <= 1'b0;
            code_q      <= 4'd0;
            illegal_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            mca_q       <= mca_d;
            mpb_q       <= mpb_d;
            acc_q       <= acc_d;
            out_valid_q <= out_valid_d;
            result_q    <= result_d;
            n_q         <= n_d;
            z_q         <= z_d;
            c_q         <= c_d;
            v_q         <= v_d;
            code_q      <= code_d;
            illegal_q   <= illegal_d;
        end
    end

    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign flag_n    = n_q;
    assign flag_z    = z_q;
    assign flag_c    = c_q;
    assign flag_v    = v_q;
    assign alu_code  = code_q;
    assign illegal   = illegal_q;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed bench for alu_exec_unit (DATA_W=64): single-cycle ops, MUL latency,
// backpressure ordering, flush and mid-MUL reset.
module tb_alu_exec_unit;

    localparam int W = 64;

    localparam logic [10:0] OP_ADD = 11'b10001011000;
    localparam logic [10:0] OP_SUB = 11'b11001011000;
    localparam logic [10:0] OP_EOR = 11'b11001010000;
    localparam logic [10:0] OP_LSL = 11'b11010011011;
    localparam logic [10:0] OP_LSR = 11'b11010011010;
    localparam logic [10:0] OP_MUL = 11'b10011011000;
    localparam logic [10:0] OP_CBZ = 11'b10110100000;

    logic         clk = 1'b0;
    logic         reset, flush, in_valid, in_ready, out_valid, out_ready;
    logic [1:0]   alu_op_class;
    logic [10:0]  opcode;
    logic [W-1:0] operand_a, operand_b, result;
    logic         flag_n, flag_z, flag_c, flag_v, illegal;
    logic [3:0]   alu_code;

    int total = 0;
    int bad = 0;
    logic [W-1:0] exp_q[$];
    logic sb_en = 1'b0;
    int n_consumed = 0;

    alu_exec_unit #(.DATA_W(W)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .alu_op_class(alu_op_class), .opcode(opcode),
        .operand_a(operand_a), .operand_b(operand_b),
        .out_valid(out_valid), .out_ready(out_ready), .result(result),
        .flag_n(flag_n), .flag_z(flag_z), .flag_c(flag_c), .flag_v(flag_v),
        .alu_code(alu_code), .illegal(illegal)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic check_out(input string tag, input logic [W-1:0] res, input logic [3:0] nzcv,
                             input logic [3:0] code, input logic ill);
        check({tag, "_valid"}, W'(out_valid), W'(1));
        check({tag, "_res"}, result, res);
        check({tag, "_nzcv"}, W'({flag_n, flag_z, flag_c, flag_v}), W'(nzcv));
        check({tag, "_code"}, W'(alu_code), W'(code));
        check({tag, "_ill"}, W'(illegal), W'(ill));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Presents one request for a single edge; returns at #1 after that edge.
    task automatic do_op(input logic [1:0] cls, input logic [10:0] opc,
                         input logic [W-1:0] a, input logic [W-1:0] b);
        in_valid = 1'b1;
        alu_op_class = cls;
        opcode = opc;
        operand_a = a;
        operand_b = b;
        tick();
        in_valid = 1'b0;
    endtask

    // Scoreboard: every consumed result must be the next expected one.
    always @(negedge clk) begin
        if (sb_en && out_valid && out_ready) begin
            n_consumed++;
            if (exp_q.size() != 0) check("sb_result", result, exp_q.pop_front());
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        logic seen;
        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        alu_op_class = 2'b00; opcode = '0; operand_a = '0; operand_b = '0;
        tick();
        tick();
        check("rst_in_ready", W'(in_ready), W'(0));
        check("rst_valid", W'(out_valid), W'(0));
        check("rst_res", result, '0);
        reset = 1'b0;
        #1;
        check("post_rst_ready", W'(in_ready), W'(1));

        do_op(2'b10, OP_ADD, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1);
        check_out("add_ovf", 64'h8000_0000_0000_0000, 4'b1001, 4'd2, 1'b0);
        do_op(2'b10, OP_SUB, 64'd5, 64'd5);
        check_out("sub_eq", 64'd0, 4'b0110, 4'd6, 1'b0);
        do_op(2'b10, OP_SUB, 64'd3, 64'd5);
        check_out("sub_borrow", 64'hFFFF_FFFF_FFFF_FFFE, 4'b1000, 4'd6, 1'b0);
        do_op(2'b10, OP_LSL, 64'd1, 64'h43);
        check_out("lsl", 64'd8, 4'b0000, 4'd4, 1'b0);
        do_op(2'b10, OP_LSR, 64'h8000_0000_0000_0000, 64'd63);
        check_out("lsr", 64'd1, 4'b0000, 4'd5, 1'b0);
        do_op(2'b10, OP_EOR, 64'hF0F0, 64'hFF00);
        check_out("eor", 64'h0FF0, 4'b0000, 4'd3, 1'b0);
        do_op(2'b00, 11'b11111000010, 64'd10, 64'd20);
        check_out("mem_add", 64'd30, 4'b0000, 4'd2, 1'b0);
        do_op(2'b01, OP_CBZ, 64'd99, 64'hABC);
        check_out("pass_b", 64'hABC, 4'b0000, 4'd7, 1'b0);
        do_op(2'b10, 11'b11111111111, 64'd7, 64'd9);
        check_out("illegal", 64'd0, 4'b0000, 4'd15, 1'b1);
        tick();
        check("drain_valid", W'(out_valid), W'(0));

        // MUL latency and busy window
        do_op(2'b10, OP_MUL, 64'hFFFF_FFFF, 64'd3);
        n = 0; seen = 1'b0;
        while (!out_valid && n < 200) begin
            if (in_ready) seen = 1'b1;
            tick();
            n++;
        end
        check("mul_latency", W'(n), W'(64));
        check("mul_busy_ready", W'(seen), W'(0));
        check_out("mul", 64'h2_FFFF_FFFD, 4'b0000, 4'd8, 1'b0);
        do_op(2'b10, OP_MUL, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2);
        n = 0;
        while (!out_valid && n < 200) begin
            tick();
            n++;
        end
        check("mul2_latency", W'(n), W'(64));
        check_out("mul_wrap", 64'hFFFF_FFFF_FFFF_FFFE, 4'b1000, 4'd8, 1'b0);
        tick();

        // Backpressure: hold first result, then drain with no bubble
        out_ready = 1'b0;
        sb_en = 1'b1;
        exp_q.push_back(64'd2);
        do_op(2'b10, OP_ADD, 64'd1, 64'd1);
        in_valid = 1'b1; operand_a = 64'd10; operand_b = 64'd20;
        #1;
        check("bp_ready_low", W'(in_ready), W'(0));
        repeat (2) begin
            tick();
            check("bp_hold_res", result, 64'd2);
            check("bp_hold_valid", W'(out_valid), W'(1));
        end
        out_ready = 1'b1;
        #1;
        check("bp_ready_high", W'(in_ready), W'(1));
        exp_q.push_back(64'd30);
        tick();
        check("bp_nobubble", W'(out_valid), W'(1));
        operand_a = 64'd50; operand_b = 64'd50;
        exp_q.push_back(64'd100);
        tick();
        in_valid = 1'b0;
        tick();
        check("bp_drained", W'(out_valid), W'(0));
        sb_en = 1'b0;
        check("bp_consumed", W'(n_consumed), W'(3));
        check("bp_queue_left", W'(exp_q.size()), W'(0));

        // Flush beats an accept in IDLE, and drops a held result
        flush = 1'b1;
        do_op(2'b10, OP_ADD, 64'd4, 64'd4);
        flush = 1'b0;
        check("flush_idle_valid", W'(out_valid), W'(0));
        out_ready = 1'b0;
        do_op(2'b10, OP_ADD, 64'd4, 64'd4);
        check("held_valid", W'(out_valid), W'(1));
        flush = 1'b1;
        tick();
        flush = 1'b0;
        out_ready = 1'b1;
        check("flush_held_valid", W'(out_valid), W'(0));

        // Flush at MUL cycle 10 with a concurrent request
        do_op(2'b10, OP_MUL, 64'd7, 64'd9);
        repeat (9) tick();
        flush = 1'b1;
        in_valid = 1'b1; alu_op_class = 2'b10; opcode = OP_ADD;
        tick();
        flush = 1'b0;
        in_valid = 1'b0;
        check("flush_mul_valid", W'(out_valid), W'(0));
        check("flush_mul_ready", W'(in_ready), W'(1));
        seen = 1'b0;
        repeat (70) begin
            tick();
            if (out_valid) seen = 1'b1;
        end
        check("flush_mul_no_result", W'(seen), W'(0));

        // Reset at MUL cycle 20 with a nonzero result still in the registers
        do_op(2'b10, OP_SUB, 64'd1, 64'd2);
        check("pre_rst_res", result, 64'hFFFF_FFFF_FFFF_FFFF);
        do_op(2'b10, OP_MUL, 64'hFFFF_FFFF, 64'd3);
        repeat (19) tick();
        reset = 1'b1;
        tick();
        check("midmul_rst_ready", W'(in_ready), W'(0));
        check("midmul_rst_valid", W'(out_valid), W'(0));
        check("midmul_rst_res", result, '0);
        check("midmul_rst_flags", W'({flag_n, flag_z, flag_c, flag_v, illegal}), W'(0));
        check("midmul_rst_code", W'(alu_code), W'(0));
        reset = 1'b0;
        #1;
        check("midmul_post_ready", W'(in_ready), W'(1));
        seen = 1'b0;
        repeat (70) begin
            tick();
            if (out_valid) seen = 1'b1;
        end
        check("midmul_no_result", W'(seen), W'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/alu_exec_unit.md
Name: alu_exec_unit

Overview:
- Execute-stage ALU for the LEGv8 pipeline.
- Accepts ALUOp class, 11-bit opcode and two operands from the ID/EX register. Registers the 4-bit ALU control decode together with the operation result.
- Adds EOR, LSL, LSR and an iterative multi-cycle MUL with a valid/ready handshake.
- Outputs result and NZCV flags to the EX/MEM register.

Parameters:
- DATA_W, 64, operand/result width; power of two, >= 8.
- SH_W, $clog2(DATA_W), width of the shift-amount field taken from operand_b.

Ports:
- clk  in  1  clock; rising edge.
- reset  in  1  synchronous, active-high reset.
- flush  in  1  synchronous kill of in-flight and output-held operation.
- in_valid  in  1  request valid.
- in_ready  out  1  unit can accept this cycle.
- alu_op_class  in  2  ALUOp from control (00 mem, 01 branch/pass, 10 R-type).
- opcode  in  11  instruction[31:21].
- operand_a  in  DATA_W  Rn value.
- operand_b  in  DATA_W  Rm value or immediate.
- out_valid  out  1  result register holds valid data.
- out_ready  in  1  downstream consumes the result.
- result  out  DATA_W  operation result.
- flag_n, flag_z, flag_c, flag_v  out  1 each  condition flags.
- alu_code  out  4  decoded ALU control code of the held result.
- illegal  out  1  held result came from an undecodable {class, opcode}.

Behaviour:
- Decode of {alu_op_class, opcode}:
  - 00_00000000000 / 00_11111000010 / 00_11111000000 -> 2 ADD
  - 01_00000000000 / 01_10110100000 -> 7 PASS_B
  - 10_10001010000 -> 0 AND
  - 10_10101010000 -> 1 ORR
  - 10_10001011000 -> 2 ADD
  - 10_11001011000 -> 6 SUB
  - 10_11001010000 -> 3 EOR
  - 10_11010011011 -> 4 LSL
  - 10_11010011010 -> 5 LSR
  - 10_10011011000 -> 8 MUL
  - anything else -> 15 with illegal=1
- Accept condition: in_valid && in_ready.
- in_ready = (state==IDLE) && (!out_valid || out_ready) && !reset. Back-to-back single-cycle ops run at full throughput.
- Single-cycle ops (codes 0-7, 15): an accept at edge k loads result, flags, alu_code and illegal, and sets out_valid after edge k.
- Arithmetic:
  - ADD: {c, sum} = a + b.
  - SUB: a + ~b + 1; c = carry out (1 = no borrow).
  - v = signed overflow for ADD/SUB only.
  - LSL/LSR shift by operand_b[SH_W-1:0], logical, zero-fill.
  - c = v = 0 for all non-ADD/SUB ops.
  - n = result[DATA_W-1]; z = (result==0).
  - Illegal ops: result 0, flags 0, code 15. The result is still delivered so the pipeline can trap.
- MUL FSM, states IDLE -> MUL -> IDLE:
  - On accept: latch the operands, clear the accumulator and counter, go to MUL.
  - Each MUL cycle does one shift-add step on multiplier bit cnt; the counter increments.
  - After DATA_W MUL cycles the low DATA_W bits of the product go to result, with n/z from that result and c = v = 0. out_valid rises and the FSM returns to IDLE.
  - An accept at edge k gives out_valid after edge k+DATA_W.
  - in_ready = 0 throughout MUL.
- Output hold: result, flags, alu_code and illegal are stable while out_valid && !out_ready.
- out_valid clears on out_ready unless a new accept loads in the same edge. Simultaneous consume and accept yields a new valid result with no bubble.
- flush:
  - Clears out_valid and aborts MUL (state -> IDLE, counter 0) at that edge.
  - Any accept presented in the same cycle is discarded; flush beats accept.
  - Result/flag registers may keep stale data.
- reset:
  - Effective at the clock edge, including mid-MUL.
  - Sets state IDLE, counter 0, out_valid 0, result 0, all flags 0, alu_code 0, illegal 0.
  - in_ready = 0 while reset is asserted and 1 on the first cycle after.
- Every output is a direct register except in_ready.

Test Plan:
- Reset, then ADD with a=0x7FFF_FFFF_FFFF_FFFF, b=1 (DATA_W=64) -> one cycle later out_valid=1, result=0x8000_0000_0000_0000, n=1, z=0, c=0, v=1, alu_code=2.
- SUB with a=5, b=5 -> result=0, z=1, c=1, v=0, code 6. Then LSL with a=1, b=0x43 -> result=8 (shamt 3 from the low 6 bits), code 4.
- MUL with a=0xFFFF_FFFF, b=3 -> in_ready low for 64 cycles, out_valid exactly 64 edges after accept, result=0x2_FFFF_FFFD, code 8.
- Backpressure: out_ready=0 with 3 single-cycle ops queued -> first result held stable, in_ready=0. Raise out_ready -> one result per cycle, no loss or duplication.
- Flush at MUL cycle 10 with a concurrent in_valid -> out_valid stays 0, state IDLE, in_ready=1 next cycle. Reset at MUL cycle 20 -> all outputs 0.
- {10, 11111111111} -> illegal=1, alu_code=15, result=0, out_valid=1 after one cycle.
